// File: rtl/spi_dac_multich_driver.sv
// Multi-channel SPI DAC driver: a double-buffered sample bank is shifted out to NUM_CH DACs
// on shared sclk/mosi with per-channel cs_n, then a shared ldac_n pulse updates all outputs together.
module spi_dac_multich_driver #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 16,
  parameter int FRAME_W    = 16,
  parameter int SCLK_DIV   = 8,
  parameter int SAMPLE_DIV = 100,
  parameter int CS_GAP     = 2,
  parameter int LDAC_W     = 2,
  parameter bit CPOL       = 1'b1
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              s_axis_valid,
  output logic              s_axis_ready,
  input  logic [DATA_W-1:0] s_axis_data,
  output logic [NUM_CH-1:0] cs_n,
  output logic              sclk,
  output logic              mosi,
  output logic              ldac_n,
  output logic              busy,
  output logic              underrun,
  output logic              overrun
);

  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FW   = $clog2(NUM_CH + 1);
  localparam int TW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW   = $clog2(SCLK_DIV);
  localparam int BW   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int GMAX = (CS_GAP > LDAC_W) ? CS_GAP : LDAC_W;
  localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(SCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_W - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);
  localparam logic [GW-1:0] LDAC_LAST = GW'(LDAC_W - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(NUM_CH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FRAME, S_GAP, S_LDAC} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     tick_cnt;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     tmr;
  logic [CW-1:0]     ch;
  logic [FW-1:0]     fill;
  logic [DATA_W-1:0] shadow [NUM_CH];
  logic [DATA_W-1:0] act    [NUM_CH];
  logic              tick, accept, bank_full, copy, div_last, bit_last;

  // Frame layout: leading zero pad, then the sample MSB first; b counts from the first bit sent.
  function automatic logic frame_bit(input logic [DATA_W-1:0] d, input logic [BW-1:0] b);
    logic [FRAME_W-1:0] w;
    w = FRAME_W'(d);
    return w[BIT_LAST - b];
  endfunction

  assign tick      = en && (tick_cnt == TICK_LAST);
  assign bank_full = (fill == FILL_FULL);
  assign copy      = (state == S_LOAD) && bank_full;
  assign accept    = s_axis_valid && s_axis_ready;
  assign div_last  = (div_cnt == DIV_LAST);
  assign bit_last  = (bit_cnt == BIT_LAST);

  assign s_axis_ready = rst_n && (fill < FILL_FULL);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n)                      tick_cnt <= '0;
    else if (!en || tick == 1'b1)    tick_cnt <= '0;
    else                             tick_cnt <= tick_cnt + 1'b1;
  end

  // Shadow bank fills from the stream; LOAD moves a complete bank into the active registers.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow[k] <= '0;
        act[k]    <= '0;
      end
    end else begin
      if (copy) begin
        for (int k = 0; k < NUM_CH; k++) act[k] <= shadow[k];
        fill <= FW'(accept);
      end else if (accept) begin
        fill <= fill + 1'b1;
      end
      if (accept) shadow[copy ? CW'(0) : CW'(fill)] <= s_axis_data;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tick) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_FRAME;
      S_FRAME: if (div_last && bit_last) state_nxt = S_GAP;
      S_GAP:   if (tmr == GAP_LAST) state_nxt = (ch == CH_LAST) ? S_LDAC : S_FRAME;
      S_LDAC:  if (tmr == LDAC_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      tmr     <= '0;
      ch      <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          tmr     <= '0;
          ch      <= '0;
        end
        S_FRAME: begin
          if (div_last) begin
            div_cnt <= '0;
            bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
            tmr     <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (tmr == GAP_LAST) begin
            tmr <= '0;
            if (ch != CH_LAST) ch <= ch + 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_LDAC:  tmr <= (tmr == LDAC_LAST) ? '0 : tmr + 1'b1;
        default: tmr <= '0;
      endcase
    end
  end

  // mosi only moves at a bit boundary, i.e. the first cycle of each low half.
  assign busy     = (state != S_IDLE);
  assign cs_n     = (state == S_FRAME) ? ~(NUM_CH'(1) << ch) : '1;
  assign sclk     = (state == S_FRAME) ? (div_cnt >= DIV_HALF) : CPOL;
  assign mosi     = (state == S_FRAME) ? frame_bit(act[ch], bit_cnt) : 1'b0;
  assign ldac_n   = (state != S_LDAC);
  assign underrun = (state == S_LOAD) && !bank_full;
  assign overrun  = tick && (state != S_IDLE);

endmodule

// File: tb/tb_spi_dac_multich_driver.sv
// Directed bench for spi_dac_multich_driver: four parameterisations share stimulus through a selector.
module tb_spi_dac_multich_driver;

  logic        mclk = 1'b0;
  logic        rst_n, en, valid;
  logic [15:0] data;
  logic [1:0]  sel;
  logic [3:0]  en_v, val_v, sclk_v, mosi_v, ldac_v, busy_v, ur_v, or_v, rdy_v;
  logic [7:0]  cs_v;
  logic [1:0]  cs_m;
  logic        sclk_m, mosi_m, ldac_m, busy_m, ur_m, or_m, rdy_m;

  int total = 0;
  int bad   = 0;
  int busy_cnt, first_cs0, ldac_cnt, ur_cnt, or_cnt, both_low, idle_edge, mosi_bad;
  int cs_low [2];
  int cs_fall[2];
  int rises  [2];
  logic [31:0] word[2];

  always #5 mclk = ~mclk;

  assign en_v   = en    ? (4'b0001 << sel) : 4'b0000;
  assign val_v  = valid ? (4'b0001 << sel) : 4'b0000;
  assign cs_m   = cs_v[{sel, 1'b0} +: 2];
  assign sclk_m = sclk_v[sel];
  assign mosi_m = mosi_v[sel];
  assign ldac_m = ldac_v[sel];
  assign busy_m = busy_v[sel];
  assign ur_m   = ur_v[sel];
  assign or_m   = or_v[sel];
  assign rdy_m  = rdy_v[sel];

  spi_dac_multich_driver d0 (
    .mclk(mclk), .rst_n(rst_n), .en(en_v[0]), .s_axis_valid(val_v[0]), .s_axis_ready(rdy_v[0]),
    .s_axis_data(data), .cs_n(cs_v[1:0]), .sclk(sclk_v[0]), .mosi(mosi_v[0]), .ldac_n(ldac_v[0]),
    .busy(busy_v[0]), .underrun(ur_v[0]), .overrun(or_v[0]));

  spi_dac_multich_driver #(.FRAME_W(24), .SAMPLE_DIV(200)) d1 (
    .mclk(mclk), .rst_n(rst_n), .en(en_v[1]), .s_axis_valid(val_v[1]), .s_axis_ready(rdy_v[1]),
    .s_axis_data(data), .cs_n(cs_v[3:2]), .sclk(sclk_v[1]), .mosi(mosi_v[1]), .ldac_n(ldac_v[1]),
    .busy(busy_v[1]), .underrun(ur_v[1]), .overrun(or_v[1]));

  spi_dac_multich_driver #(.SAMPLE_DIV(150)) d2 (
    .mclk(mclk), .rst_n(rst_n), .en(en_v[2]), .s_axis_valid(val_v[2]), .s_axis_ready(rdy_v[2]),
    .s_axis_data(data), .cs_n(cs_v[5:4]), .sclk(sclk_v[2]), .mosi(mosi_v[2]), .ldac_n(ldac_v[2]),
    .busy(busy_v[2]), .underrun(ur_v[2]), .overrun(or_v[2]));

  spi_dac_multich_driver #(.CPOL(1'b0), .SCLK_DIV(2)) d3 (
    .mclk(mclk), .rst_n(rst_n), .en(en_v[3]), .s_axis_valid(val_v[3]), .s_axis_ready(rdy_v[3]),
    .s_axis_data(data), .cs_n(cs_v[7:6]), .sclk(sclk_v[3]), .mosi(mosi_v[3]), .ldac_n(ldac_v[3]),
    .busy(busy_v[3]), .underrun(ur_v[3]), .overrun(or_v[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    int w;
    valid = 1'b1;
    data  = d;
    w     = 0;
    while (!rdy_m && w < 50) begin
      step(1);
      w++;
    end
    chk("send_ready", {31'd0, rdy_m}, 32'd1);
    step(1);
    valid = 1'b0;
  endtask

  // Observe the selected DUT for n cycles, gathering frame contents and protocol statistics.
  task automatic watch(input int n);
    logic [1:0] pcs;
    logic       psclk, pmosi;
    busy_cnt = 0; first_cs0 = 0; ldac_cnt = 0; ur_cnt = 0; or_cnt = 0;
    both_low = 0; idle_edge = 0; mosi_bad = 0;
    for (int k = 0; k < 2; k++) begin
      cs_low[k] = 0; cs_fall[k] = 0; rises[k] = 0; word[k] = '0;
    end
    pcs = cs_m; psclk = sclk_m; pmosi = mosi_m;
    for (int i = 1; i <= n; i++) begin
      step(1);
      if (busy_m)  busy_cnt++;
      if (!ldac_m) ldac_cnt++;
      if (ur_m)    ur_cnt++;
      if (or_m)    or_cnt++;
      if (cs_m == 2'b00) both_low++;
      if (pcs == 2'b11 && cs_m == 2'b11 && sclk_m != psclk) idle_edge++;
      for (int k = 0; k < 2; k++) begin
        if (!cs_m[k]) cs_low[k]++;
        if (pcs[k] && !cs_m[k]) cs_fall[k]++;
        if (!cs_m[k] && !psclk && sclk_m) begin
          rises[k]++;
          word[k] = {word[k][30:0], mosi_m};
          if (mosi_m !== pmosi) mosi_bad++;
        end
      end
      if (first_cs0 == 0 && !cs_m[0]) first_cs0 = i;
      pcs = cs_m; psclk = sclk_m; pmosi = mosi_m;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; valid = 1'b0; data = '0; sel = 2'd0;
    step(3);
    chk("rst_cs_n",   {30'd0, cs_m}, 32'h3);
    chk("rst_sclk",   {31'd0, sclk_m}, 32'd1);
    chk("rst_mosi",   {31'd0, mosi_m}, 32'd0);
    chk("rst_ldac_n", {31'd0, ldac_m}, 32'd1);
    chk("rst_busy",   {31'd0, busy_m}, 32'd0);
    chk("rst_flags",  {30'd0, ur_m, or_m}, 32'd0);
    chk("rst_ready",  {31'd0, rdy_m}, 32'd0);
    sel = 2'd3;
    #1;
    chk("rst_sclk_cpol0", {31'd0, sclk_m}, 32'd0);
    sel = 2'd0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, rdy_m}, 32'd1);

    // Test 1: default part, bank {A5A5, 0F0F}
    send(16'hA5A5);
    send(16'h0F0F);
    chk("t1_full_ready", {31'd0, rdy_m}, 32'd0);
    en = 1'b1;
    watch(390);
    en = 1'b0;
    chk("t1_first_cs0", first_cs0, 32'd101);
    chk("t1_word0",     word[0], 32'h0000A5A5);
    chk("t1_word1",     word[1], 32'h00000F0F);
    chk("t1_rises0",    rises[0], 32'd16);
    chk("t1_rises1",    rises[1], 32'd16);
    chk("t1_cs_low0",   cs_low[0], 32'd128);
    chk("t1_cs_low1",   cs_low[1], 32'd128);
    chk("t1_ldac",      ldac_cnt, 32'd2);
    chk("t1_busy",      busy_cnt, 32'd263);
    chk("t1_both_low",  both_low, 32'd0);
    chk("t1_idle_edge", idle_edge, 32'd0);
    chk("t1_underrun",  ur_cnt, 32'd0);
    chk("t1_overrun",   or_cnt, 32'd2);
    chk("t1_ready",     {31'd0, rdy_m}, 32'd1);

    // Test 2: partial bank at tick retransmits the old bank
    send(16'h1234);
    chk("t2_ready_half", {31'd0, rdy_m}, 32'd1);
    en = 1'b1;
    watch(390);
    en = 1'b0;
    chk("t2_underrun", ur_cnt, 32'd1);
    chk("t2_word0",    word[0], 32'h0000A5A5);
    chk("t2_word1",    word[1], 32'h00000F0F);
    send(16'h5678);
    chk("t2_full_ready", {31'd0, rdy_m}, 32'd0);
    en = 1'b1;
    watch(390);
    en = 1'b0;
    chk("t2b_underrun", ur_cnt, 32'd0);
    chk("t2b_word0",    word[0], 32'h00001234);
    chk("t2b_word1",    word[1], 32'h00005678);

    // Test 3: 24-bit frame, 8 pad zeros then FFFF
    sel = 2'd1;
    #1;
    send(16'hFFFF);
    send(16'hFFFF);
    en = 1'b1;
    watch(595);
    en = 1'b0;
    chk("t3_first_cs0", first_cs0, 32'd201);
    chk("t3_word0",     word[0], 32'h0000FFFF);
    chk("t3_word1",     word[1], 32'h0000FFFF);
    chk("t3_rises0",    rises[0], 32'd24);
    chk("t3_cs_low0",   cs_low[0], 32'd192);
    chk("t3_cs_low1",   cs_low[1], 32'd192);
    chk("t3_busy",      busy_cnt, 32'd391);
    chk("t3_overrun",   or_cnt, 32'd1);

    // Test 4: SAMPLE_DIV=150 overruns every other tick
    sel = 2'd2;
    #1;
    send(16'h1111);
    send(16'h2222);
    en = 1'b1;
    watch(620);
    en = 1'b0;
    chk("t4_overrun",  or_cnt, 32'd2);
    chk("t4_underrun", ur_cnt, 32'd1);
    chk("t4_fall0",    cs_fall[0], 32'd2);
    chk("t4_fall1",    cs_fall[1], 32'd2);
    chk("t4_both_low", both_low, 32'd0);
    chk("t4_word0",    word[0], 32'h11111111);

    // Test 5: asynchronous reset in bit 7 of ch0
    sel = 2'd0;
    #1;
    send(16'hCAFE);
    send(16'hBEEF);
    en = 1'b1;
    step(160);
    chk("t5_mid_frame", {30'd0, cs_m}, 32'h2);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("t5_cs_n",   {30'd0, cs_m}, 32'h3);
    chk("t5_sclk",   {31'd0, sclk_m}, 32'd1);
    chk("t5_mosi",   {31'd0, mosi_m}, 32'd0);
    chk("t5_ldac_n", {31'd0, ldac_m}, 32'd1);
    chk("t5_busy",   {31'd0, busy_m}, 32'd0);
    chk("t5_ready",  {31'd0, rdy_m}, 32'd0);
    step(1);
    rst_n = 1'b1;
    #1;
    chk("t5_ready_rel", {31'd0, rdy_m}, 32'd1);
    watch(300);
    chk("t5_quiet_fall", cs_fall[0] + cs_fall[1], 32'd0);
    chk("t5_quiet_busy", busy_cnt, 32'd0);
    send(16'h1357);
    send(16'h2468);
    en = 1'b1;
    watch(390);
    en = 1'b0;
    chk("t5_first_cs0", first_cs0, 32'd101);
    chk("t5_word0",     word[0], 32'h00001357);
    chk("t5_word1",     word[1], 32'h00002468);

    // Test 6: CPOL=0, SCLK_DIV=2
    sel = 2'd3;
    #1;
    send(16'h8001);
    send(16'h7FFE);
    en = 1'b1;
    watch(180);
    en = 1'b0;
    chk("t6_word0",     word[0], 32'h00008001);
    chk("t6_word1",     word[1], 32'h00007FFE);
    chk("t6_rises0",    rises[0], 32'd16);
    chk("t6_rises1",    rises[1], 32'd16);
    chk("t6_mosi_hold", mosi_bad, 32'd0);
    chk("t6_both_low",  both_low, 32'd0);
    chk("t6_idle_edge", idle_edge, 32'd0);
    chk("t6_cs_low0",   cs_low[0], 32'd32);
    chk("t6_busy",      busy_cnt, 32'd71);
    chk("t6_ldac",      ldac_cnt, 32'd2);
    chk("t6_overrun",   or_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
